// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multi-cycle MIPS controller.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPE_EX, S_RTYPE_WB, S_BEQ, S_ADDI_EX, S_ADDI_WB, S_JUMP
  } state_e;
  typedef enum logic [1:0] {AC_ADD, AC_SUB, AC_FUNC} alu_class_e;
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/alu_control.sv
// alu_control: maps the ALU usage class and func field to an ALU operation.
module alu_control
  import mips_pkg::*;
(
  input  alu_class_e  cls_i,
  input  logic [5:0]  func_i,
  output logic [2:0]  alu_op_o,
  output logic        illegal_func_o
);
  always_comb begin
    alu_op_o = ALU_ADD;
    illegal_func_o = 1'b0;
    if (cls_i == AC_SUB) alu_op_o = ALU_SUB;
    else if (cls_i == AC_FUNC)
      case (func_i)
        F_ADD:   alu_op_o = ALU_ADD;
        F_SUB:   alu_op_o = ALU_SUB;
        F_AND:   alu_op_o = ALU_AND;
        F_OR:    alu_op_o = ALU_OR;
        F_SLT:   alu_op_o = ALU_SLT;
        default: illegal_func_o = 1'b1;
      endcase
  end
endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multi-cycle FSM sequencing a shared ALU/memory MIPS datapath.
module mips_mc_controller
  import mips_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       IorD_o,
  output logic       IRWrite_o,
  output logic       pc_en_o,
  output logic [1:0] PCSource_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ALUoperation_o,
  output logic       RegWrite_o,
  output logic       RegDst_o,
  output logic       MemtoReg_o,
  output logic       illegal_o
);
  state_e     state_q, state_d;
  alu_class_e cls;
  ctrl_t      c, o;
  logic       pc_write, branch, illegal_op, illegal_func;
  logic [2:0] alu_op;
  alu_control u_alu_control (
    .cls_i          (cls),
    .func_i         (func_i),
    .alu_op_o       (alu_op),
    .illegal_func_o (illegal_func)
  );
  always_ff @(posedge clk_i) state_q <= rst_ni ? state_d : S_FETCH;
  always_comb begin
    c = '0;
    state_d = state_q;
    cls = AC_ADD;
    pc_write = 1'b0;
    branch = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        c.mem_read = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write = mem_ready_i;
        pc_write = mem_ready_i;
        state_d = mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        case (opcode_i)
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        state_d = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord = 1'b1;
        state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        c.reg_write = 1'b1;
        c.memto_reg = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord = 1'b1;
        state_d = mem_ready_i ? S_FETCH : S_MEMWR;
      end
      S_RTYPE_EX: begin
        c.alu_src_a = 1'b1;
        cls = AC_FUNC;
        state_d = illegal_func ? S_FETCH : S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        c.alu_src_a = 1'b1;
        cls = AC_SUB;
        branch = 1'b1;
        c.pc_source = 2'b01;
        state_d = S_FETCH;
      end
      S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        c.reg_write = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        c.pc_source = 2'b10;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    c.alu_op = alu_op;
    c.pc_en = pc_write | (branch & zero_i);
    c.illegal = illegal_op | illegal_func;
  end
  // Every output is forced low while reset is held, including the FETCH strobes.
  assign o = rst_ni ? c : '0;
  assign mem_read_o = o.mem_read;
  assign mem_write_o = o.mem_write;
  assign IorD_o = o.iord;
  assign IRWrite_o = o.ir_write;
  assign pc_en_o = o.pc_en;
  assign PCSource_o = o.pc_source;
  assign ALUSrcA_o = o.alu_src_a;
  assign ALUSrcB_o = o.alu_src_b;
  assign ALUoperation_o = o.alu_op;
  assign RegWrite_o = o.reg_write;
  assign RegDst_o = o.reg_dst;
  assign MemtoReg_o = o.memto_reg;
  assign illegal_o = o.illegal;
endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: table-driven instruction sequences with a scoreboard of per-instruction results.
module tb_mips_mc_controller;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = '0, func = '0;
  logic zero = 1'b0, mem_ready = 1'b1;
  logic mem_read, mem_write, IorD, IRWrite, pc_en, ALUSrcA, RegWrite, RegDst, MemtoReg, illegal;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALUoperation;
  int errors = 0, checks = 0;

  mips_mc_controller dut (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .func_i(func), .zero_i(zero),
    .mem_ready_i(mem_ready), .mem_read_o(mem_read), .mem_write_o(mem_write), .IorD_o(IorD),
    .IRWrite_o(IRWrite), .pc_en_o(pc_en), .PCSource_o(PCSource), .ALUSrcA_o(ALUSrcA),
    .ALUSrcB_o(ALUSrcB), .ALUoperation_o(ALUoperation), .RegWrite_o(RegWrite),
    .RegDst_o(RegDst), .MemtoReg_o(MemtoReg), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         fw;
    int         mw;
    int         cyc;
    int         rw;
    logic       rd;
    logic       m2r;
    int         pcen;
    logic [1:0] pcsrc;
    int         ill;
    logic [2:0] alu;
  } vec_t;

  vec_t tv[13];
  vec_t sb[$];

  function automatic logic [17:0] all_outs();
    return {mem_read, mem_write, IorD, IRWrite, pc_en, PCSource, ALUSrcA, ALUSrcB,
            ALUoperation, RegWrite, RegDst, MemtoReg, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_instr(input int idx, input vec_t v);
    int cyc = 0, rw = 0, pcen = 0, ill = 0, irw = 0, bad = 0, wc = 0, ph = 0, last_ph = -1;
    logic rd = 1'b0, m2r = 1'b0;
    logic [1:0] pcsrc = 2'b00;
    logic [2:0] alu = 3'b100;
    logic prev_fetch;
    vec_t e;
    string n;
    sb.push_back(v);
    opcode = v.op;
    func = v.fn;
    zero = v.z;
    forever begin
      ph = (mem_read && !IorD) ? 1 : (IorD && (mem_read || mem_write)) ? 2 : 0;
      if (ph != last_ph) wc = 0;
      last_ph = ph;
      mem_ready = (ph == 1) ? (wc >= v.fw) : (ph == 2) ? (wc >= v.mw) : 1'($urandom_range(0, 1));
      wc++;
      #1;
      cyc++;
      rw += int'(RegWrite);
      pcen += int'(pc_en);
      ill += int'(illegal);
      irw += int'(IRWrite);
      if (ALUSrcA) alu = ALUoperation;
      if (RegWrite) begin rd = RegDst; m2r = MemtoReg; end
      if (pc_en && !IRWrite) pcsrc = PCSource;
      if ((mem_read && mem_write) || (RegWrite && pc_en) || (IRWrite && !mem_ready)) bad++;
      prev_fetch = mem_read && !IorD;
      @(posedge clk);
      #1;
      if (mem_read && !IorD && !prev_fetch) break;
      if (cyc > 40) begin
        chk($sformatf("v%0d timeout", idx), 32'(cyc), 32'(v.cyc));
        break;
      end
    end
    e = sb.pop_front();
    n = $sformatf("v%0d op=%b fn=%b", idx, e.op, e.fn);
    chk({n, " cycles"}, 32'(cyc), 32'(e.cyc));
    chk({n, " regwrite"}, 32'(rw), 32'(e.rw));
    chk({n, " regdst"}, 32'(rd), 32'(e.rd));
    chk({n, " memtoreg"}, 32'(m2r), 32'(e.m2r));
    chk({n, " pc_en"}, 32'(pcen), 32'(e.pcen));
    chk({n, " pcsource"}, 32'(pcsrc), 32'(e.pcsrc));
    chk({n, " illegal"}, 32'(ill), 32'(e.ill));
    chk({n, " aluop"}, 32'(alu), 32'(e.alu));
    chk({n, " irwrite"}, 32'(irw), 32'd1);
    chk({n, " hazards"}, 32'(bad), 32'd0);
  endtask

  initial begin
    //            op         fn         z   fw mw cyc rw rd   m2r  pcen pcsrc  ill alu
    tv[0]  = '{6'b000000, 6'b100000, 1'b0, 0, 0, 4, 1, 1'b1, 1'b0, 1, 2'b00, 0, 3'b010};
    tv[1]  = '{6'b000000, 6'b100010, 1'b0, 1, 0, 5, 1, 1'b1, 1'b0, 1, 2'b00, 0, 3'b110};
    tv[2]  = '{6'b000000, 6'b100100, 1'b1, 0, 0, 4, 1, 1'b1, 1'b0, 1, 2'b00, 0, 3'b000};
    tv[3]  = '{6'b000000, 6'b100101, 1'b0, 0, 0, 4, 1, 1'b1, 1'b0, 1, 2'b00, 0, 3'b001};
    tv[4]  = '{6'b000000, 6'b101010, 1'b0, 0, 0, 4, 1, 1'b1, 1'b0, 1, 2'b00, 0, 3'b111};
    tv[5]  = '{6'b100011, 6'b000000, 1'b0, 2, 2, 9, 1, 1'b0, 1'b1, 1, 2'b00, 0, 3'b010};
    tv[6]  = '{6'b101011, 6'b000000, 1'b1, 0, 1, 5, 0, 1'b0, 1'b0, 1, 2'b00, 0, 3'b010};
    tv[7]  = '{6'b000100, 6'b000000, 1'b1, 0, 0, 3, 0, 1'b0, 1'b0, 2, 2'b01, 0, 3'b110};
    tv[8]  = '{6'b000100, 6'b000000, 1'b0, 0, 0, 3, 0, 1'b0, 1'b0, 1, 2'b00, 0, 3'b110};
    tv[9]  = '{6'b001000, 6'b000000, 1'b0, 0, 0, 4, 1, 1'b0, 1'b0, 1, 2'b00, 0, 3'b010};
    tv[10] = '{6'b000010, 6'b000000, 1'b1, 0, 0, 3, 0, 1'b0, 1'b0, 2, 2'b10, 0, 3'b100};
    tv[11] = '{6'b111111, 6'b000000, 1'b0, 0, 0, 2, 0, 1'b0, 1'b0, 1, 2'b00, 1, 3'b100};
    tv[12] = '{6'b000000, 6'b000111, 1'b0, 0, 0, 3, 0, 1'b0, 1'b0, 1, 2'b00, 1, 3'b010};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("reset outs cyc%0d", i), 32'(all_outs()), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("first fetch mem_read", 32'(mem_read), 32'd1);
    chk("first fetch IorD", 32'(IorD), 32'd0);
    for (int i = 0; i < 13; i++) run_instr(i, tv[i]);
    opcode = 6'b101011;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    #1;
    chk("sw memwr strobe", 32'({mem_write, IorD}), 32'b11);
    @(posedge clk);
    #1;
    chk("sw memwr held", 32'({mem_write, IorD}), 32'b11);
    rst_n = 1'b0;
    #1;
    chk("sw reset cycle outs", 32'(all_outs()), 32'd0);
    @(posedge clk);
    #1;
    chk("sw reset held outs", 32'(all_outs()), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("sw refetch", 32'({mem_read, IorD, mem_write}), 32'b100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
